// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-core definitions: widths, reset vector default, state encoding, FIFO entry layout.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; flush overrides push and pop.
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC sequencing, memory req/ack, redirect and in-flight drain handling.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  fetch_state_e state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  drain_addr, drain_d;
  logic         push, pop, flush;
  logic         full, empty;
  fetch_entry_t din, head;

  assign din         = '{pc: pc, instr: mem_rdata};
  assign instr_valid = ~empty;
  assign instr       = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR & ALIGN_MASK;
      drain_addr <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drain_addr <= drain_d;
    end
  end

  // Request is held stable until ack: count cannot grow without an ack, and a
  // redirect against a pending request parks the old address in DRAIN.
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    drain_d  = drain_addr;
    push     = 1'b0;
    flush    = 1'b0;
    pop      = instr_valid & instr_ready;
    mem_req  = 1'b0;
    mem_addr = pc;

    case (state)
      FETCH: mem_req = rst_n & ~full;
      DRAIN: begin
        mem_req  = rst_n;
        mem_addr = drain_addr;
      end
      default: ;
    endcase

    if (redirect_valid) begin
      flush = 1'b1;
      pop   = 1'b0;
      pc_d  = redirect_pc & ALIGN_MASK;
      if (state == FETCH && mem_req && !mem_ack) begin
        drain_d = pc;
        state_d = DRAIN;
      end
    end else if (state == FETCH) begin
      if (mem_req && mem_ack) begin
        push = 1'b1;
        pc_d = pc + 32'd4;
      end
    end else if (mem_req && mem_ack) begin
      state_d = FETCH;
    end
  end

endmodule
